// File: rtl/ocx_dlx_xlx_pkg.sv
// Shared definitions for the OpenCAPI DLx-to-transceiver TX bring-up interface.
package ocx_dlx_xlx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RST_PULSE = 3'd1,
        ST_WAIT_RST  = 3'd2,
        ST_BYP_START = 3'd3,
        ST_WAIT_BYP  = 3'd4,
        ST_READY     = 3'd5,
        ST_ERROR     = 3'd6
    } tx_state_t;

    localparam int DEF_PULSE_CYCLES   = 8;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/ocx_dlx_xlx_tmo_cnt.sv
// Watchdog counter bounding each wait on a PHY done signal.
module ocx_dlx_xlx_tmo_cnt
    import ocx_dlx_xlx_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/ocx_dlx_xlx_tx_if.sv
// TX bring-up sequencer between the DLx and the transceiver wizard:
// datapath reset pulse, buffer-bypass alignment, then lane valid gating.
module ocx_dlx_xlx_tx_if
    import ocx_dlx_xlx_pkg::*;
#(
    parameter int LANES          = 8,
    parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic             opt_gckn,
    input  logic             reset_n,
    input  logic             dlx_tx_start,
    input  logic             dlx_tx_retrain,
    input  logic             gtwiz_reset_tx_done_in,
    input  logic             gtwiz_buffbypass_tx_done_in,
    input  logic             gtwiz_userclk_tx_active_in,
    output logic             gtwiz_reset_tx_datapath_out,
    output logic             gtwiz_buffbypass_tx_start_out,
    input  logic [LANES-1:0] ln_tx_valid_in,
    output logic [LANES-1:0] ln_tx_valid_out,
    output logic [LANES-1:0] io_pb_o0_tx_init_done,
    output logic             tx_timeout_err
);

    localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);

    tx_state_t        state_q, state_nxt;
    logic             run_q;
    logic [PW-1:0]    pulse_cnt_q;
    logic             datapath_rst_q;
    logic             byp_start_q;
    logic [LANES-1:0] init_done_q;
    logic             err_q, err_nxt;
    logic             tmo_clr, tmo_en, tmo_expired;

    // run_q holds the FSM for one edge after reset release so deassertion is seen synchronously
    always_ff @(posedge opt_gckn or negedge reset_n) begin
        if (!reset_n) begin
            run_q          <= 1'b0;
            state_q        <= ST_IDLE;
            pulse_cnt_q    <= '0;
            datapath_rst_q <= 1'b0;
            byp_start_q    <= 1'b0;
            init_done_q    <= '0;
            err_q          <= 1'b0;
        end else begin
            run_q          <= 1'b1;
            state_q        <= state_nxt;
            pulse_cnt_q    <= (state_q == ST_RST_PULSE && state_nxt == ST_RST_PULSE)
                              ? pulse_cnt_q + PW'(1) : '0;
            datapath_rst_q <= (state_nxt == ST_RST_PULSE);
            byp_start_q    <= (state_nxt == ST_BYP_START);
            init_done_q    <= {LANES{state_nxt == ST_READY}};
            err_q          <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (!run_q) begin
            state_nxt = state_q;
        end else if (!dlx_tx_start) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:      if (gtwiz_userclk_tx_active_in) state_nxt = ST_RST_PULSE;
                ST_RST_PULSE: if (pulse_cnt_q == PULSE_LAST) state_nxt = ST_WAIT_RST;
                ST_WAIT_RST: begin
                    if (gtwiz_reset_tx_done_in)   state_nxt = ST_BYP_START;
                    else if (tmo_expired)         state_nxt = ST_ERROR;
                end
                ST_BYP_START: state_nxt = ST_WAIT_BYP;
                ST_WAIT_BYP: begin
                    if (gtwiz_buffbypass_tx_done_in) state_nxt = ST_READY;
                    else if (tmo_expired)            state_nxt = ST_ERROR;
                end
                ST_READY: begin
                    if (dlx_tx_retrain)
                        state_nxt = ST_RST_PULSE;
                    else if (!gtwiz_reset_tx_done_in || !gtwiz_buffbypass_tx_done_in)
                        state_nxt = ST_WAIT_RST;
                end
                ST_ERROR:     state_nxt = ST_ERROR;
                default:      state_nxt = ST_IDLE;
            endcase
        end
    end

    // Error is sticky: only leaving ERROR through IDLE (or reset) clears it
    always_comb begin
        err_nxt = err_q;
        if (state_nxt == ST_ERROR)
            err_nxt = 1'b1;
        else if (state_q == ST_ERROR && state_nxt == ST_IDLE)
            err_nxt = 1'b0;
    end

    assign tmo_en  = (state_q == ST_WAIT_RST) || (state_q == ST_WAIT_BYP);
    assign tmo_clr = (state_nxt != state_q);

    ocx_dlx_xlx_tmo_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo_cnt (
        .clk     (opt_gckn),
        .rst_n   (reset_n),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    assign gtwiz_reset_tx_datapath_out   = datapath_rst_q;
    assign gtwiz_buffbypass_tx_start_out = byp_start_q;
    assign io_pb_o0_tx_init_done         = init_done_q;
    assign tx_timeout_err                = err_q;
    assign ln_tx_valid_out               = (state_q == ST_READY) ? ln_tx_valid_in : '0;

endmodule

// File: tb/tb_ocx_dlx_xlx_tx_if.sv
// Directed bench for the TX bring-up sequencer.
module tb_ocx_dlx_xlx_tx_if;

    localparam int LANES = 8;

    logic             opt_gckn;
    logic             reset_n;
    logic             dlx_tx_start;
    logic             dlx_tx_retrain;
    logic             gtwiz_reset_tx_done_in;
    logic             gtwiz_buffbypass_tx_done_in;
    logic             gtwiz_userclk_tx_active_in;
    logic             gtwiz_reset_tx_datapath_out;
    logic             gtwiz_buffbypass_tx_start_out;
    logic [LANES-1:0] ln_tx_valid_in;
    logic [LANES-1:0] ln_tx_valid_out;
    logic [LANES-1:0] io_pb_o0_tx_init_done;
    logic             tx_timeout_err;

    int checks   = 0;
    int failures = 0;

    ocx_dlx_xlx_tx_if #(
        .LANES          (LANES),
        .PULSE_CYCLES   (8),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .opt_gckn                      (opt_gckn),
        .reset_n                       (reset_n),
        .dlx_tx_start                  (dlx_tx_start),
        .dlx_tx_retrain                (dlx_tx_retrain),
        .gtwiz_reset_tx_done_in        (gtwiz_reset_tx_done_in),
        .gtwiz_buffbypass_tx_done_in   (gtwiz_buffbypass_tx_done_in),
        .gtwiz_userclk_tx_active_in    (gtwiz_userclk_tx_active_in),
        .gtwiz_reset_tx_datapath_out   (gtwiz_reset_tx_datapath_out),
        .gtwiz_buffbypass_tx_start_out (gtwiz_buffbypass_tx_start_out),
        .ln_tx_valid_in                (ln_tx_valid_in),
        .ln_tx_valid_out               (ln_tx_valid_out),
        .io_pb_o0_tx_init_done         (io_pb_o0_tx_init_done),
        .tx_timeout_err                (tx_timeout_err)
    );

    initial opt_gckn = 1'b0;
    always #5 opt_gckn = ~opt_gckn;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge opt_gckn);
        #1;
    endtask

    // Counts consecutive high cycles of the datapath reset; returns on its falling sample
    task automatic measure_pulse(output int width);
        width = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (gtwiz_reset_tx_datapath_out) width++;
            else if (width > 0) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int w;
        int n;

        reset_n                     = 1'b0;
        dlx_tx_start                = 1'b0;
        dlx_tx_retrain              = 1'b0;
        gtwiz_reset_tx_done_in      = 1'b0;
        gtwiz_buffbypass_tx_done_in = 1'b0;
        gtwiz_userclk_tx_active_in  = 1'b0;
        ln_tx_valid_in              = 8'hFF;
        repeat (3) step();

        // Reset state, even with start requested
        dlx_tx_start               = 1'b1;
        gtwiz_userclk_tx_active_in = 1'b1;
        step();
        chk("rst_datapath", 32'(gtwiz_reset_tx_datapath_out), 32'd0);
        chk("rst_byp_start", 32'(gtwiz_buffbypass_tx_start_out), 32'd0);
        chk("rst_err", 32'(tx_timeout_err), 32'd0);
        chk("rst_init_done", 32'(io_pb_o0_tx_init_done), 32'h00);
        chk("rst_valid_out", 32'(ln_tx_valid_out), 32'h00);

        // Release: first edge must not transition
        reset_n = 1'b1;
        step();
        chk("release_hold", 32'(gtwiz_reset_tx_datapath_out), 32'd0);

        // Nominal bring-up
        ln_tx_valid_in = 8'hA5;
        measure_pulse(w);
        chk("nom_pulse_width", 32'(w), 32'd8);
        chk("nom_wait_rst_byp", 32'(gtwiz_buffbypass_tx_start_out), 32'd0);
        step();
        dlx_tx_retrain = 1'b1;
        step();
        dlx_tx_retrain = 1'b0;
        chk("retrain_ignored", 32'(gtwiz_reset_tx_datapath_out), 32'd0);
        step();
        step();
        gtwiz_reset_tx_done_in = 1'b1;
        step();
        chk("byp_start_hi", 32'(gtwiz_buffbypass_tx_start_out), 32'd1);
        step();
        chk("byp_start_lo", 32'(gtwiz_buffbypass_tx_start_out), 32'd0);
        chk("wait_byp_valid", 32'(ln_tx_valid_out), 32'h00);
        chk("wait_byp_init", 32'(io_pb_o0_tx_init_done), 32'h00);
        gtwiz_buffbypass_tx_done_in = 1'b1;
        step();
        chk("ready_init", 32'(io_pb_o0_tx_init_done), 32'hFF);
        chk("ready_valid_a5", 32'(ln_tx_valid_out), 32'hA5);
        ln_tx_valid_in = 8'h3C;
        #1;
        chk("ready_valid_3c", 32'(ln_tx_valid_out), 32'h3C);

        // Retrain and loss of tx_done together: retrain wins
        dlx_tx_retrain         = 1'b1;
        gtwiz_reset_tx_done_in = 1'b0;
        step();
        dlx_tx_retrain = 1'b0;
        chk("retrain_pulse", 32'(gtwiz_reset_tx_datapath_out), 32'd1);
        chk("retrain_init", 32'(io_pb_o0_tx_init_done), 32'h00);
        measure_pulse(w);
        chk("retrain_rest_width", 32'(w), 32'd7);
        gtwiz_reset_tx_done_in = 1'b1;
        step();
        step();
        step();
        chk("retrain_ready", 32'(io_pb_o0_tx_init_done), 32'hFF);

        // Loss of bypass done in READY falls back to WAIT_RST, not a new pulse
        gtwiz_buffbypass_tx_done_in = 1'b0;
        step();
        chk("loss_init", 32'(io_pb_o0_tx_init_done), 32'h00);
        chk("loss_no_pulse", 32'(gtwiz_reset_tx_datapath_out), 32'd0);
        gtwiz_buffbypass_tx_done_in = 1'b1;
        step();
        chk("loss_byp_start", 32'(gtwiz_buffbypass_tx_start_out), 32'd1);
        step();
        step();
        chk("loss_ready", 32'(io_pb_o0_tx_init_done), 32'hFF);

        dlx_tx_start = 1'b0;
        step();
        chk("stop_idle_init", 32'(io_pb_o0_tx_init_done), 32'h00);

        // Timeout in WAIT_RST
        gtwiz_reset_tx_done_in      = 1'b0;
        gtwiz_buffbypass_tx_done_in = 1'b0;
        dlx_tx_start                = 1'b1;
        measure_pulse(w);
        chk("tmo_pulse_width", 32'(w), 32'd8);
        n = 1;
        for (int i = 0; i < 2000 && !tx_timeout_err; i++) begin
            step();
            if (!tx_timeout_err) n++;
        end
        chk("tmo_wait_cycles", 32'(n), 32'd1024);
        chk("tmo_err_set", 32'(tx_timeout_err), 32'd1);
        gtwiz_reset_tx_done_in = 1'b1;
        repeat (3) step();
        chk("tmo_err_sticky", 32'(tx_timeout_err), 32'd1);
        chk("tmo_no_byp", 32'(gtwiz_buffbypass_tx_start_out), 32'd0);
        dlx_tx_start = 1'b0;
        step();
        chk("tmo_err_clear", 32'(tx_timeout_err), 32'd0);

        // Bypass done arriving on the last timeout cycle wins
        gtwiz_reset_tx_done_in = 1'b0;
        dlx_tx_start           = 1'b1;
        measure_pulse(w);
        chk("edge_pulse_width", 32'(w), 32'd8);
        gtwiz_reset_tx_done_in = 1'b1;
        step();
        chk("edge_byp_start", 32'(gtwiz_buffbypass_tx_start_out), 32'd1);
        step();
        repeat (1023) step();
        chk("edge_no_err_yet", 32'(tx_timeout_err), 32'd0);
        gtwiz_buffbypass_tx_done_in = 1'b1;
        step();
        chk("edge_ready", 32'(io_pb_o0_tx_init_done), 32'hFF);
        chk("edge_no_err", 32'(tx_timeout_err), 32'd0);

        // Asynchronous reset in the middle of the pulse
        dlx_tx_start = 1'b0;
        step();
        dlx_tx_start = 1'b1;
        repeat (3) step();
        chk("mid_pulse_hi", 32'(gtwiz_reset_tx_datapath_out), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_datapath", 32'(gtwiz_reset_tx_datapath_out), 32'd0);
        chk("async_init", 32'(io_pb_o0_tx_init_done), 32'h00);
        step();
        step();
        reset_n = 1'b1;
        step();
        chk("rerelease_hold", 32'(gtwiz_reset_tx_datapath_out), 32'd0);
        measure_pulse(w);
        chk("restart_width", 32'(w), 32'd8);
        step();
        step();
        step();
        chk("restart_ready", 32'(io_pb_o0_tx_init_done), 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
